// File: rtl/vga_timing_gen.sv
// VGA display timing generator: sync/DE generation, one-cycle-ahead pixel request, 2-stage output pipeline.
// Optional build macro VGA_COLORBAR_EN replaces frame-buffer pixels with an 8-bar test pattern.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned RGB_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [RGB_W-1:0] pix_rgb,
  output logic             data_req,
  output logic [9:0]       req_x,
  output logic [9:0]       req_y,
  output logic             frame_start,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [RGB_W-1:0] vga_rgb
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_E = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_E = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_S  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_E  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_ACT_S  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_E  = 11'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;

  logic        req_q, req_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        fs_q, fs_d;
  logic        hs0_q, hs0_d;
  logic        vs0_q, vs0_d;

  logic             hs1_q, vs1_q, de1_q;
  logic             vga_hs_q, vga_vs_q, vga_de_q;
  logic [RGB_W-1:0] vga_rgb_q;
  logic [RGB_W-1:0] pix_sel;

  // The first enabled edge out of IDLE holds the counters at (0,0) so that
  // the stage-0 registers load the decode of (0,0) and frame_start fires.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (state_q == ST_IDLE) begin
      state_d = ST_RUN;
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end else begin
      h_cnt_d = h_cnt_q + 11'd1;
    end
  end

  // Lookahead decode of the next counter value keeps stage-0 aligned with the counters.
  always_comb begin
    req_d = (h_cnt_d >= H_ACT_S) && (h_cnt_d < H_ACT_E) &&
            (v_cnt_d >= V_ACT_S) && (v_cnt_d < V_ACT_E);
    x_d   = '0;
    y_d   = '0;
    if (req_d) begin
      x_d = 10'(h_cnt_d - H_ACT_S);
      y_d = 10'(v_cnt_d - V_ACT_S);
    end
    fs_d  = (h_cnt_d == '0) && (v_cnt_d == '0);
    hs0_d = (h_cnt_d < H_SYNC_E) ? HS_POL : !HS_POL;
    vs0_d = (v_cnt_d < V_SYNC_E) ? VS_POL : !VS_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      state_q   <= ST_IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      req_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      hs0_q     <= !HS_POL;
      vs0_q     <= !VS_POL;
      hs1_q     <= !HS_POL;
      vs1_q     <= !VS_POL;
      de1_q     <= 1'b0;
      vga_hs_q  <= !HS_POL;
      vga_vs_q  <= !VS_POL;
      vga_de_q  <= 1'b0;
      vga_rgb_q <= '0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      req_q     <= req_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      hs0_q     <= hs0_d;
      vs0_q     <= vs0_d;
      hs1_q     <= hs0_q;
      vs1_q     <= vs0_q;
      de1_q     <= req_q;
      vga_hs_q  <= hs1_q;
      vga_vs_q  <= vs1_q;
      vga_de_q  <= de1_q;
      vga_rgb_q <= de1_q ? pix_sel : '0;
    end
  end

`ifdef VGA_COLORBAR_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [9:0] x1_q;
  logic [2:0] bar_idx;
  logic       unused_pix;

  assign unused_pix = ^pix_rgb;

  // Column of the request one cycle back lines up with the frame-buffer latency slot.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      x1_q <= '0;
    end else begin
      x1_q <= x_q;
    end
  end

  always_comb begin
    bar_idx = 3'(x1_q / 10'(BAR_W));
    pix_sel = '0;
    case (bar_idx)
      3'd0:    pix_sel = RGB_W'(16'hFFFF);
      3'd1:    pix_sel = RGB_W'(16'hFFE0);
      3'd2:    pix_sel = RGB_W'(16'h07FF);
      3'd3:    pix_sel = RGB_W'(16'h07E0);
      3'd4:    pix_sel = RGB_W'(16'hF81F);
      3'd5:    pix_sel = RGB_W'(16'hF800);
      3'd6:    pix_sel = RGB_W'(16'h001F);
      default: pix_sel = RGB_W'(16'h0000);
    endcase
  end
`else
  always_comb begin
    pix_sel = pix_rgb;
  end
`endif

  assign data_req    = req_q;
  assign req_x       = x_q;
  assign req_y       = y_q;
  assign frame_start = fs_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_de      = vga_de_q;
  assign vga_rgb     = vga_rgb_q;

endmodule
